speed_command_scheduler: RTL and testbench

Upstream stage of the JSON UART command sender. Turns a requested drive speed digit (from the perception/control logic) into a rate-limited sequence of send requests. It ramps the commanded speed one step at a time and re-sends periodically as a heartbeat. An emergency stop pre-empts the ramp. It exposes a valid/ready command handshake and waits for transmit-complete before issuing the next command.

---
 rtl/speed_sched_pkg.sv | 20 ++
 rtl/cycle_tick_timer.sv | 33 +++
 rtl/speed_command_scheduler.sv | 155 +++++++++++++++
 tb/tb_speed_command_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_sched_pkg.sv
// Shared types and constants for the speed command scheduler.
package speed_sched_pkg;

    localparam int SPEED_W         = 4;
    localparam int SPEED_MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_t;

    function automatic logic [SPEED_W-1:0] clamp_speed(
        input logic [SPEED_W-1:0] speed,
        input logic [SPEED_W-1:0] limit
    );
        return (speed > limit) ? limit : speed;
    endfunction

endpackage

// File: rtl/cycle_tick_timer.sv
// Period counter with clear/enable; wraps (tick at PERIOD-1) or saturates
// (tick on the single cycle the count is about to reach PERIOD-1).
module cycle_tick_timer #(
    parameter int PERIOD   = 10,
    parameter bit SATURATE = 1'b0,
    parameter int CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic          tick,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST     = CW'(PERIOD - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(PERIOD - 2);

    // Saturating mode flags the arrival edge, so a parked count never re-fires.
    assign tick = en && !clr && (count == (SATURATE ? PRE_LAST : LAST));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST)
                count <= SATURATE ? LAST : '0;
            else
                count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/speed_command_scheduler.sv
// Ramps a requested speed digit one step per ramp period and issues
// valid/ready send requests, with heartbeat re-send, estop and tx timeout.
module speed_command_scheduler
    import speed_sched_pkg::*;
#(
    parameter int SPEED_MAX        = 9,
    parameter int RAMP_CYCLES      = 5_000_000,
    parameter int HEARTBEAT_CYCLES = 25_000_000,
    parameter int TIMEOUT_CYCLES   = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SPEED_W-1:0] target_speed,
    input  logic               target_valid,
    input  logic               estop,
    output logic [SPEED_W-1:0] cmd_speed,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    input  logic               tx_done,
    output logic [SPEED_W-1:0] current_speed,
    output logic               busy,
    output logic               timeout_err
);

    localparam logic [SPEED_W-1:0] LIMIT =
        SPEED_W'((SPEED_MAX > SPEED_MAX_DIGIT) ? SPEED_MAX_DIGIT : SPEED_MAX);
    localparam int RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam int HB_W   = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    sched_state_t       state_reg;
    logic [SPEED_W-1:0] target_reg;
    logic [SPEED_W-1:0] current_reg;
    logic [SPEED_W-1:0] current_next;
    logic [SPEED_W-1:0] cmd_speed_reg;
    logic               cmd_valid_reg;
    logic               busy_reg;
    logic               timeout_err_reg;
    logic               pending_reg;
    logic               estop_prev_reg;

    logic               ramp_tick;
    logic               hb_tick;
    logic               to_tick;
    logic [RAMP_W-1:0]  ramp_count_unused;
    logic [HB_W-1:0]    hb_count_unused;
    logic [TO_W-1:0]    to_count_unused;

    logic handshake;
    logic take;
    logic timed_out;
    logic pending_set;

    assign handshake = cmd_valid_reg && cmd_ready;
    assign take      = (state_reg == IDLE) && pending_reg;
    assign timed_out = (state_reg == WAIT_DONE) && !tx_done && to_tick;

    cycle_tick_timer #(.PERIOD(RAMP_CYCLES), .SATURATE(1'b0), .CW(RAMP_W)) ramp_timer (
        .clk(clk), .rst(rst), .clr(estop), .en(1'b1),
        .tick(ramp_tick), .count(ramp_count_unused)
    );

    cycle_tick_timer #(.PERIOD(HEARTBEAT_CYCLES), .SATURATE(1'b1), .CW(HB_W)) hb_timer (
        .clk(clk), .rst(rst), .clr(handshake), .en(1'b1),
        .tick(hb_tick), .count(hb_count_unused)
    );

    cycle_tick_timer #(.PERIOD(TIMEOUT_CYCLES), .SATURATE(1'b0), .CW(TO_W)) to_timer (
        .clk(clk), .rst(rst), .clr(handshake), .en(state_reg == WAIT_DONE),
        .tick(to_tick), .count(to_count_unused)
    );

    always_comb begin
        current_next = current_reg;
        if (estop)
            current_next = '0;
        else if (ramp_tick) begin
            if (current_reg < target_reg)
                current_next = current_reg + 4'd1;
            else if (current_reg > target_reg)
                current_next = current_reg - 4'd1;
        end
    end

    assign pending_set = (current_next != current_reg) || hb_tick
                       || (estop && !estop_prev_reg) || timed_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            target_reg     <= '0;
            current_reg    <= '0;
            pending_reg    <= 1'b1;
            estop_prev_reg <= 1'b0;
        end else begin
            estop_prev_reg <= estop;
            current_reg    <= current_next;
            if (estop)
                target_reg <= '0;
            else if (target_valid)
                target_reg <= clamp_speed(target_speed, LIMIT);
            // A new request arriving as the old one is taken must survive.
            pending_reg <= pending_set || (pending_reg && !take);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cmd_speed_reg   <= '0;
            cmd_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pending_reg) begin
                        cmd_speed_reg <= current_reg;
                        cmd_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= REQ;
                    end
                end
                REQ: begin
                    if (cmd_ready) begin
                        cmd_valid_reg <= 1'b0;
                        state_reg     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (to_tick) begin
                        timeout_err_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                        state_reg       <= IDLE;
                    end
                end
                default: begin
                    cmd_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_speed     = cmd_speed_reg;
    assign cmd_valid     = cmd_valid_reg;
    assign current_speed = current_reg;
    assign busy          = busy_reg;
    assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_speed_command_scheduler.sv
// Directed bench for speed_command_scheduler: ramp table plus reset, estop,
// heartbeat, timeout and back-pressure sequences.
module tb_speed_command_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] target_speed = 4'd0;
    logic       target_valid = 1'b0;
    logic       estop = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       tx_done = 1'b0;
    logic [3:0] cmd_speed;
    logic [3:0] current_speed;
    logic       cmd_valid;
    logic       busy;
    logic       timeout_err;

    speed_command_scheduler #(
        .SPEED_MAX(9), .RAMP_CYCLES(10), .HEARTBEAT_CYCLES(100), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst),
        .target_speed(target_speed), .target_valid(target_valid), .estop(estop),
        .cmd_speed(cmd_speed), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .tx_done(tx_done), .current_speed(current_speed),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tgt;
        int exp_final;
        int exp_first;
        int exp_n;
    } row_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int tx_cnt = 0;
    bit tx_enable = 1'b1;
    int hs_speed[$];
    int hs_edge[$];
    int to_cnt = 0;
    int to_edge = 0;
    int stab_err = 0;
    int max_cur = 0;
    bit prev_valid = 1'b0;
    logic [3:0] prev_speed = 4'd0;

    // Sender model and transaction log; negedge k follows posedge k, so a
    // handshake seen here completes on posedge k+1.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            tx_done = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) tx_done = 1'b1;
            end
            if (!rst) begin
                if (cmd_valid && cmd_ready) begin
                    hs_speed.push_back(int'(cmd_speed));
                    hs_edge.push_back(cyc + 1);
                    if (tx_enable) tx_cnt = 5;
                    $display("handshake edge=%0d speed=%0d", cyc + 1, cmd_speed);
                end
                if (timeout_err) begin
                    to_cnt++;
                    to_edge = cyc;
                    $display("timeout_err edge=%0d", cyc);
                end
                if (cmd_valid && prev_valid && cmd_speed != prev_speed) stab_err++;
                if (int'(current_speed) > max_cur) max_cur = int'(current_speed);
            end
            prev_valid = cmd_valid;
            prev_speed = cmd_speed;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int s);
        target_speed = 4'(s);
        target_valid = 1'b1;
        cycles(1);
        target_valid = 1'b0;
    endtask

    task automatic apply_row(input row_t r);
        int n0;
        int got;
        int dir;
        n0 = hs_speed.size();
        strobe(r.tgt);
        cycles(r.exp_n * 10 + 25);
        check("row_speed", int'(current_speed), r.exp_final);
        got = hs_speed.size() - n0;
        check("row_sends", got, r.exp_n);
        dir = (r.exp_final >= r.exp_first) ? 1 : -1;
        for (int k = 0; k < got; k++) begin
            check("row_value", hs_speed[n0 + k], r.exp_first + dir * k);
            if (k > 0) check("row_spacing", hs_edge[n0 + k] - hs_edge[n0 + k - 1], 10);
        end
        check("row_busy", int'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t rows[3];
        int n0;
        int t0;
        bit found;
        int spd;

        rows[0] = '{tgt: 3,  exp_final: 3, exp_first: 1, exp_n: 3};
        rows[1] = '{tgt: 12, exp_final: 9, exp_first: 4, exp_n: 6};
        rows[2] = '{tgt: 5,  exp_final: 5, exp_first: 8, exp_n: 4};

        // Reset state
        cycles(3);
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_cmd_speed", int'(cmd_speed), 0);
        check("rst_current", int'(current_speed), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_timeout", int'(timeout_err), 0);

        // Stop command right after reset
        rst = 1'b0;
        found = 1'b0;
        spd = -1;
        for (int i = 0; i < 2; i++) begin
            cycles(1);
            if (cmd_valid && !found) begin
                found = 1'b1;
                spd = int'(cmd_speed);
            end
        end
        check("boot_valid", int'(found), 1);
        check("boot_speed", spd, 0);
        cycles(12);
        check("boot_sends", hs_speed.size(), 1);
        if (hs_speed.size() > 0) check("boot_hs_speed", hs_speed[0], 0);
        check("boot_busy", int'(busy), 0);

        // Ramp table: up, saturated up, down
        for (int i = 0; i < 3; i++) apply_row(rows[i]);

        // Estop with a competing target strobe
        n0 = hs_speed.size();
        estop = 1'b1;
        target_valid = 1'b1;
        target_speed = 4'd7;
        cycles(1);
        check("estop_speed", int'(current_speed), 0);
        cycles(2);
        estop = 1'b0;
        target_valid = 1'b0;
        cycles(40);
        check("estop_hold", int'(current_speed), 0);
        check("estop_sends", hs_speed.size() - n0, 1);
        if (hs_speed.size() > n0) check("estop_cmd", hs_speed[n0], 0);

        apply_row('{tgt: 2, exp_final: 2, exp_first: 1, exp_n: 2});

        // Heartbeat: valid rises 100 cycles after the last handshake, ready=1
        // so each handshake lands one cycle later (101-cycle spacing).
        n0 = hs_speed.size();
        for (int i = 0; i < 400 && hs_speed.size() < n0 + 2; i++) cycles(1);
        check("hb_sends", hs_speed.size() - n0, 2);
        if (hs_speed.size() >= n0 + 2) begin
            check("hb_speed0", hs_speed[n0], 2);
            check("hb_speed1", hs_speed[n0 + 1], 2);
            check("hb_gap0", hs_edge[n0] - hs_edge[n0 - 1], 101);
            check("hb_gap1", hs_edge[n0 + 1] - hs_edge[n0], 101);
        end

        // Timeout with tx_done suppressed, then retry
        cycles(10);
        tx_enable = 1'b0;
        n0 = hs_speed.size();
        t0 = to_cnt;
        strobe(3);
        for (int i = 0; i < 200 && to_cnt == t0; i++) cycles(1);
        tx_enable = 1'b1;
        cycles(20);
        check("to_pulses", to_cnt - t0, 1);
        check("to_sends", hs_speed.size() - n0, 2);
        if (hs_speed.size() >= n0 + 2) begin
            check("to_first", hs_speed[n0], 3);
            check("to_delay", to_edge - hs_edge[n0], 50);
            check("to_retry", hs_speed[n0 + 1], 3);
            check("to_retry_edge", hs_edge[n0 + 1] - to_edge, 2);
        end
        check("to_busy", int'(busy), 0);

        // Back-pressure during a ramp: held value, then skip to latest
        cmd_ready = 1'b0;
        n0 = hs_speed.size();
        strobe(7);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycles(1);
            found = cmd_valid;
        end
        check("bp_valid", int'(found), 1);
        cycles(20);
        cmd_ready = 1'b1;
        cycles(40);
        check("bp_sends", hs_speed.size() - n0, 3);
        if (hs_speed.size() >= n0 + 3) begin
            check("bp_held", hs_speed[n0], 4);
            check("bp_latest", hs_speed[n0 + 1], 6);
            check("bp_final_cmd", hs_speed[n0 + 2], 7);
        end
        check("bp_speed", int'(current_speed), 7);
        check("bp_stable", stab_err, 0);

        check("max_speed", max_cur, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
